// File: rtl/fetch_unit_pkg.sv
// Shared constants, defaults and FSM encoding for the instruction fetch stage.
package fetch_unit_pkg;
    localparam int          ADDR_W_DEF   = 7;
    localparam int          RESET_PC_DEF = 0;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory bus: fetch address out, combinational instruction word back.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] adrs;
    logic [31:0]       instr;

    modport master (output adrs, input instr);
    modport slave  (input adrs, output instr);
endinterface

// File: rtl/fetch_pc.sv
// Program counter register and next-PC selection for the fetch stage.
module fetch_pc
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] target,
    fetch_unit_if.master      bus,
    output logic              fetch_ok
);
    logic [ADDR_W-1:0] pc;

    assign bus.adrs = pc;
    // An all-zero word marks an empty ROM slot, which ends the program.
    assign fetch_ok = (bus.instr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target & ~ADDR_W'(3);
        end else if (run && !stall && fetch_ok) begin
            pc <= pc + ADDR_W'(4);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage top: run/halt FSM, IF/ID pipeline register and fetch counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    output logic [ADDR_W-1:0] imemAdrs,
    input  logic [31:0]       imemInstr,
    output logic [31:0]       ifidInstr,
    output logic [ADDR_W-1:0] ifidPc,
    output logic              ifidValid,
    output logic              halted,
    output logic [15:0]       fetchCount
);
    fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    state_t state;
    logic   fetch_ok;

    assign imemAdrs  = bus.adrs;
    assign bus.instr = imemInstr;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .run      (state == RUN),
        .stall    (stall),
        .redirect (branchTaken),
        .target   (branchTarget),
        .bus      (bus),
        .fetch_ok (fetch_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ifidInstr  <= NOP;
            ifidPc     <= '0;
            ifidValid  <= 1'b0;
            state      <= RUN;
            halted     <= 1'b0;
            fetchCount <= '0;
        end else if (branchTaken) begin
            ifidInstr <= NOP;
            ifidValid <= 1'b0;
            state     <= RUN;
            halted    <= 1'b0;
        end else if (state == HALT) begin
            ifidValid <= 1'b0;
        end else if (stall) begin
            ifidValid <= ifidValid;
        end else if (fetch_ok) begin
            ifidInstr <= imemInstr;
            ifidPc    <= bus.adrs;
            ifidValid <= 1'b1;
            if (fetchCount != 16'hFFFF) begin
                fetchCount <= fetchCount + 16'd1;
            end
        end else begin
            ifidInstr <= NOP;
            ifidValid <= 1'b0;
            state     <= HALT;
            halted    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a small combinational ROM model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] I_A = 32'h0050_0093;
    localparam logic [31:0] I_B = 32'h0030_0113;
    localparam logic [31:0] I_C = 32'h0020_81B3;
    localparam logic [31:0] I_D = 32'h4020_8233;
    localparam logic [31:0] I_E = 32'h0010_8093;
    localparam logic [31:0] I_F = 32'h0011_0113;
    localparam logic [31:0] I_G = 32'h0000_0513;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branchTaken;
    logic [6:0]  branchTarget;
    logic [31:0] ifidInstr;
    logic [6:0]  ifidPc;
    logic        ifidValid;
    logic        halted;
    logic [15:0] fetchCount;
    logic [31:0] rom [32];

    int passed = 0;
    int total  = 0;

    fetch_unit_if #(.ADDR_W(7)) rom_bus ();

    assign rom_bus.instr = rom[rom_bus.adrs[6:2]];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .imemAdrs     (rom_bus.adrs),
        .imemInstr    (rom_bus.instr),
        .ifidInstr    (ifidInstr),
        .ifidPc       (ifidPc),
        .ifidValid    (ifidValid),
        .halted       (halted),
        .fetchCount   (fetchCount)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic core(input string tag, input logic [6:0] adrs,
                        input logic [31:0] instr, input logic valid,
                        input logic hlt, input logic [15:0] cnt);
        chk({tag, ".adrs"},   32'(rom_bus.adrs), 32'(adrs));
        chk({tag, ".instr"},  ifidInstr,         instr);
        chk({tag, ".valid"},  32'(ifidValid),    32'(valid));
        chk({tag, ".halted"}, 32'(halted),       32'(hlt));
        chk({tag, ".count"},  32'(fetchCount),   32'(cnt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h0;
        rom[0]  = I_A;
        rom[1]  = I_B;
        rom[2]  = I_C;
        rom[3]  = I_D;
        rom[4]  = I_E;
        rom[5]  = I_F;
        rom[31] = I_G;

        rst = 1'b1; stall = 1'b1; branchTaken = 1'b1; branchTarget = 7'h44;
        step();
        core("reset", 7'h00, NOP, 1'b0, 1'b0, 16'd0);
        chk("reset.ifidPc", 32'(ifidPc), 32'h00);

        rst = 1'b0; stall = 1'b0; branchTaken = 1'b0;
        step();
        core("fetch0", 7'h04, I_A, 1'b1, 1'b0, 16'd1);
        chk("fetch0.ifidPc", 32'(ifidPc), 32'h00);
        step();
        core("fetch1", 7'h08, I_B, 1'b1, 1'b0, 16'd2);
        chk("fetch1.ifidPc", 32'(ifidPc), 32'h04);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            core("stall", 7'h08, I_B, 1'b1, 1'b0, 16'd2);
            chk("stall.ifidPc", 32'(ifidPc), 32'h04);
        end

        stall = 1'b0;
        step();
        core("release", 7'h0C, I_C, 1'b1, 1'b0, 16'd3);
        chk("release.ifidPc", 32'(ifidPc), 32'h08);
        step();
        step();
        step();
        core("fetch14", 7'h18, I_F, 1'b1, 1'b0, 16'd6);
        chk("fetch14.ifidPc", 32'(ifidPc), 32'h14);

        step();
        core("halt", 7'h18, NOP, 1'b0, 1'b1, 16'd6);
        stall = 1'b1;
        step();
        core("halt_stall", 7'h18, NOP, 1'b0, 1'b1, 16'd6);
        stall = 1'b0;
        step();
        core("halt_hold", 7'h18, NOP, 1'b0, 1'b1, 16'd6);

        branchTaken = 1'b1; branchTarget = 7'h1B; stall = 1'b1;
        step();
        core("br_stall", 7'h18, NOP, 1'b0, 1'b0, 16'd6);

        branchTaken = 1'b0; stall = 1'b0;
        step();
        core("rehalt", 7'h18, NOP, 1'b0, 1'b1, 16'd6);

        branchTaken = 1'b1; branchTarget = 7'h7E;
        step();
        core("br_7c", 7'h7C, NOP, 1'b0, 1'b0, 16'd6);
        branchTaken = 1'b0;
        step();
        core("wrap", 7'h00, I_G, 1'b1, 1'b0, 16'd7);
        chk("wrap.ifidPc", 32'(ifidPc), 32'h7C);
        step();
        core("after_wrap", 7'h04, I_A, 1'b1, 1'b0, 16'd8);
        chk("after_wrap.ifidPc", 32'(ifidPc), 32'h00);

        branchTaken = 1'b1; branchTarget = 7'h09;
        step();
        core("br_run", 7'h08, NOP, 1'b0, 1'b0, 16'd8);
        branchTaken = 1'b0;
        step();
        core("br_fetch", 7'h0C, I_C, 1'b1, 1'b0, 16'd9);
        chk("br_fetch.ifidPc", 32'(ifidPc), 32'h08);

        rst = 1'b1; branchTaken = 1'b1; branchTarget = 7'h40; stall = 1'b1;
        step();
        core("rst_mid", 7'h00, NOP, 1'b0, 1'b0, 16'd0);
        chk("rst_mid.ifidPc", 32'(ifidPc), 32'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning byte-address width of the instruction ROM.
REQ-002 SHALL have parameter RESET_PC, default 7'h00, meaning the PC loaded on reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port stall, input, 1, meaning hold PC and IF/ID register this cycle.
REQ-006 SHALL have port branchTaken, input, 1, meaning redirect fetch and flush IF/ID.
REQ-007 SHALL have port branchTarget, input, ADDR_W, meaning the redirect byte address.
REQ-008 SHALL have port imemAdrs, output, ADDR_W, meaning the fetch address driven to the instruction memory readAdrs.
REQ-009 SHALL have port imemInstr, input, 32, meaning the instruction word returned combinationally by the instruction memory.
REQ-010 SHALL have port ifidInstr, output, 32, meaning the registered instruction for decode.
REQ-011 SHALL have port ifidPc, output, ADDR_W, meaning the address of ifidInstr.
REQ-012 SHALL have port ifidValid, output, 1, meaning ifidInstr is a real fetched instruction.
REQ-013 SHALL have port halted, output, 1, meaning the FSM is in HALT.
REQ-014 SHALL have port fetchCount, output, 16, meaning the count of instructions accepted into IF/ID.

Function
REQ-015 SHALL drive imemAdrs = pc combinationally; fetched word appears on ifidInstr one cycle later.
REQ-016 SHALL implement FSM states RUN and HALT.
REQ-017 Priority per cycle SHALL be: rst > branchTaken > stall > normal fetch.
REQ-018 On branchTaken (either state): pc <= {branchTarget[ADDR_W-1:2],2'b00}; ifidInstr <= NOP (32'h00000013); ifidValid <= 0; state <= RUN; fetchCount unchanged.
REQ-019 On stall without branchTaken: pc, IF/ID registers, state, fetchCount hold.
REQ-020 RUN, normal fetch, imemInstr != 0: pc <= pc+4 modulo 2^ADDR_W (7'h7C -> 7'h00); ifidInstr <= imemInstr; ifidPc <= pc; ifidValid <= 1; fetchCount <= fetchCount+1, saturating at 16'hFFFF.
REQ-021 RUN, normal fetch, imemInstr == 32'h0 (empty ROM slot): state <= HALT; pc holds; ifidInstr <= NOP; ifidValid <= 0; fetchCount unchanged.
REQ-022 HALT without branchTaken: pc and state hold; ifidValid = 0; stall has no effect.
REQ-023 halted SHALL equal (state == HALT), registered.

Reset
REQ-024 On rst: pc <= RESET_PC; ifidInstr <= NOP; ifidPc <= 0; ifidValid <= 0; state <= RUN; fetchCount <= 0; halted <= 0.
REQ-025 rst asserted mid-operation SHALL override concurrent branchTaken and stall in the same cycle.

Structure
REQ-026 Shared package SHALL hold NOP constant, ADDR_W default, RESET_PC default, FSM state encoding.
REQ-027 PC register plus next-PC mux SHALL be one sub-module, fetch_pc; FSM, IF/ID register, counter stay in fetch_unit.

Verification
REQ-028 Reset, then 3 clean fetches of addi/addi/add words -> imemAdrs 00,04,08,0C; ifidPc 00,04,08; ifidValid 1; fetchCount 3.
REQ-029 Fetch at 7'h14, then imemInstr = 0 at 7'h18 -> halted 1, pc holds 7'h18, ifidValid 0, fetchCount frozen.
REQ-030 branchTaken with branchTarget 7'h1B while stall = 1 -> pc 7'h18, ifidInstr 32'h00000013, ifidValid 0, FSM RUN.
REQ-031 pc 7'h7C, normal fetch -> pc wraps to 7'h00, ifidPc 7'h7C.
REQ-032 stall held 3 cycles at pc 7'h08 -> all outputs unchanged; release -> pc 7'h0C next cycle.
REQ-033 rst with branchTaken and stall high -> all REQ-024 reset values, pc = RESET_PC.
